// File: rtl/conv2d_stream.sv
// ---------------------------------------------------------------------------
// conv2d_stream
//   Streaming K x K 2D convolution over a raster-scan pixel stream. K-1 line
//   buffers supply the K rows of each column and a K x K register window
//   slides across them. One result is produced per fully populated window
//   position; no padding is applied.
//
//   Pipeline: S1 multiplies (products registered), S2 sums (accumulator
//   registered), S3 rounds half-up, narrows and registers out_data. A result
//   appears 3 cycles after its window's bottom-right pixel is accepted. When
//   out_valid is high and out_ready is low, every stage holds.
//
//   Compile-time option:
//     CONV_SATURATE_EN  defined   : clamp the rounded result to the OUT_W range
//                       undefined : keep the low OUT_W bits (two's-complement wrap)
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start                     frame start pulse, honoured only in IDLE
//   cfg_width, cfg_height     frame size, sampled on an accepted start
//   coeff_we/addr/data        coefficient write port (index r*K+c), IDLE only
//   in_valid/in_ready/in_data pixel stream input
//   out_valid/out_ready/out_data  filtered sample output
//   busy                      high from an accepted start until done
//   done                      one-cycle end-of-frame pulse
// ---------------------------------------------------------------------------
module conv2d_stream #(
   parameter int DATA_W  = 12,
   parameter int COEFF_W = 8,
   parameter int K       = 5,
   parameter int IMG_W   = 64,
   parameter int OUT_W   = 12,
   parameter int SHIFT   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [$clog2(IMG_W+1)-1:0] cfg_width,
   input  logic [15:0]                cfg_height,
   input  logic                       coeff_we,
   input  logic [$clog2(K*K)-1:0]     coeff_addr,
   input  logic signed [COEFF_W-1:0]  coeff_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [DATA_W-1:0]   in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [OUT_W-1:0]    out_data,
   output logic                       busy,
   output logic                       done
);

   localparam int WD_W   = $clog2(IMG_W + 1);
   localparam int COL_W  = $clog2(IMG_W);
   localparam int NTAP   = K * K;
   localparam int PROD_W = DATA_W + COEFF_W;
   localparam int ACC_W  = PROD_W + $clog2(NTAP);
   // One guard bit so adding the rounding constant can never overflow.
   localparam int RND_W  = ACC_W + 1;

   localparam logic [WD_W-1:0]         K_W       = WD_W'(K);
   localparam logic [WD_W-1:0]         KM1_W     = WD_W'(K - 1);
   localparam logic [WD_W-1:0]         MAX_W     = WD_W'(IMG_W);
   localparam logic [15:0]             K_H       = 16'(K);
   localparam logic [15:0]             KM1_H     = 16'(K - 1);
   localparam logic signed [RND_W-1:0] RND_CONST = RND_W'((2 ** SHIFT) >> 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

   state_t                     state_q, state_d;
   logic [WD_W-1:0]            cfg_w_q;
   logic [15:0]                cfg_h_q;
   logic [WD_W-1:0]            col;
   logic [15:0]                row;
   logic [COL_W-1:0]           col_idx;

   logic signed [COEFF_W-1:0]  coeff    [NTAP];
   logic signed [DATA_W-1:0]   line_buf [K-1][IMG_W];
   logic signed [DATA_W-1:0]   col_vec  [K];
   logic signed [DATA_W-1:0]   win      [K][K];
   logic signed [DATA_W-1:0]   win_next [K][K];
   logic signed [PROD_W-1:0]   prod     [NTAP];
   logic signed [ACC_W-1:0]    acc_sum, acc;
   logic signed [OUT_W-1:0]    narrowed;

   logic v1, v2;
   logic stall, accept, cfg_ok, start_ok, last_pix, win_ok, pipe_empty;

   // ---------------------------------------------------------------- control
   assign stall      = out_valid && !out_ready;
   assign accept     = in_valid && in_ready;
   assign cfg_ok     = (cfg_width >= K_W) && (cfg_width <= MAX_W) && (cfg_height >= K_H);
   assign start_ok   = (state_q == IDLE) && start && cfg_ok;
   assign last_pix   = (col == cfg_w_q - 1'b1) && (row == cfg_h_q - 1'b1);
   assign win_ok     = (col >= KM1_W) && (row >= KM1_H);
   // Empty once S1/S2 hold nothing and S3 is either empty or handing off now.
   assign pipe_empty = !v1 && !v2 && (!out_valid || out_ready);
   assign col_idx    = col[COL_W-1:0];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok)          state_d = ACTIVE;
         ACTIVE:  if (accept && last_pix) state_d = DRAIN;
         DRAIN:   if (pipe_empty)        state_d = IDLE;
         default:                        state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         ACTIVE: begin
            in_ready = !stall;
            busy     = 1'b1;
         end
         DRAIN: begin
            done = pipe_empty;
            busy = !pipe_empty;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_w_q <= '0;
         cfg_h_q <= '0;
         col     <= '0;
         row     <= '0;
      end else if (start_ok) begin
         cfg_w_q <= cfg_width;
         cfg_h_q <= cfg_height;
         col     <= '0;
         row     <= '0;
      end else if (accept) begin
         if (col == cfg_w_q - 1'b1) begin
            col <= '0;
            row <= row + 16'd1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NTAP; i++) coeff[i] <= '0;
      end else if (coeff_we && state_q == IDLE) begin
         coeff[coeff_addr] <= coeff_data;
      end
   end

   // ------------------------------------------------------- line buffer chain
   // Row 0 of the column is the oldest line, row K-1 the incoming pixel.
   always_comb begin
      col_vec[K-1] = in_data;
      for (int i = 0; i < K - 1; i++) col_vec[K-2-i] = line_buf[i][col_idx];
   end

   // NOTE: the line buffers and window are plain storage with no reset; any
   // stale content is never used because a window only counts once K rows and
   // K columns of the current frame have passed through it.
   always_ff @(posedge clk) begin
      if (accept) begin
         line_buf[0][col_idx] <= in_data;
         for (int i = 1; i < K - 1; i++) line_buf[i][col_idx] <= line_buf[i-1][col_idx];
      end
   end

   // The window shifts left; the new column enters at c = K-1.
   always_comb begin
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++) win_next[r][c] = win[r][c+1];
         win_next[r][K-1] = col_vec[r];
      end
   end

   always_ff @(posedge clk) begin
      if (accept) win <= win_next;
   end

   // -------------------------------------------------------------- datapath
   // S1 multiplies the post-shift window directly so the window register and
   // the product register load on the same edge.
   always_ff @(posedge clk) begin
      if (!stall) begin
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
               prod[r*K+c] <= PROD_W'(win_next[r][c]) * PROD_W'(coeff[r*K+c]);
         acc <= acc_sum;
      end
   end

   always_comb begin
      acc_sum = '0;
      for (int i = 0; i < NTAP; i++) acc_sum = acc_sum + ACC_W'(prod[i]);
   end

`ifdef CONV_SATURATE_EN
   localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [RND_W-1:0] SAT_MIN = -SAT_MAX - RND_W'(1);
   logic signed [RND_W-1:0] rnd;

   always_comb begin
      rnd = (RND_W'(acc) + RND_CONST) >>> SHIFT;
      if (rnd > SAT_MAX)      narrowed = OUT_W'(SAT_MAX);
      else if (rnd < SAT_MIN) narrowed = OUT_W'(SAT_MIN);
      else                    narrowed = OUT_W'(rnd);
   end
`else
   always_comb narrowed = OUT_W'((RND_W'(acc) + RND_CONST) >>> SHIFT);
`endif

   // Valid bits ride alongside the data; a bubble simply clears its slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (!stall) begin
         v1        <= accept && win_ok;
         v2        <= v1;
         out_valid <= v2;
         if (v2) out_data <= narrowed;
      end
   end

endmodule

// File: tb/tb_conv2d_stream.sv
// ---------------------------------------------------------------------------
// tb_conv2d_stream
//   Self-checking bench for conv2d_stream. Expected results come from a
//   direct arithmetic model: for every window position the K x K dot product
//   is formed from a 2D pixel array, rounded half up, then clamped or wrapped
//   according to CONV_SATURATE_EN.
// ---------------------------------------------------------------------------
module tb_conv2d_stream;

   localparam int DATA_W  = 12;
   localparam int COEFF_W = 8;
   localparam int K       = 5;
   localparam int IMG_W   = 64;
   localparam int OUT_W   = 12;
   localparam int SHIFT   = 4;
   localparam int WD_W    = $clog2(IMG_W + 1);
   localparam int NTAP    = K * K;
   localparam int AW      = $clog2(NTAP);
   localparam int CENTER  = (K / 2) * K + K / 2;

   logic                      clk        = 1'b0;
   logic                      rst        = 1'b1;
   logic                      start      = 1'b0;
   logic [WD_W-1:0]           cfg_width  = '0;
   logic [15:0]               cfg_height = '0;
   logic                      coeff_we   = 1'b0;
   logic [AW-1:0]             coeff_addr = '0;
   logic signed [COEFF_W-1:0] coeff_data = '0;
   logic                      in_valid   = 1'b0;
   logic                      in_ready;
   logic signed [DATA_W-1:0]  in_data    = '0;
   logic                      out_valid;
   logic                      out_ready  = 1'b1;
   logic signed [OUT_W-1:0]   out_data;
   logic                      busy;
   logic                      done;

   conv2d_stream #(
      .DATA_W(DATA_W), .COEFF_W(COEFF_W), .K(K),
      .IMG_W(IMG_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_width(cfg_width), .cfg_height(cfg_height),
      .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int coef [NTAP];
   int pix  [16][16];
   int exp_q [$];
   int got_q [$];
   int done_cnt;
   int first_out_cyc = -1;
   int acc_cyc       = -1;
   bit bp_mode    = 1'b0;
   bit first_seen = 1'b0;
   int hold       = 0;
   bit prev_stall = 1'b0;
   bit prev_busy  = 1'b0;
   int prev_data  = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Output-side driver: full throughput, or random backpressure with the
   // first result of the frame held off for 5 cycles.
   always begin
      @(posedge clk);
      #1;
      if (!bp_mode) out_ready = 1'b1;
      else if (hold > 0) begin
         out_ready = 1'b0;
         hold--;
      end else if (out_valid && !first_seen) begin
         first_seen = 1'b1;
         hold       = 4;
         out_ready  = 1'b0;
      end else out_ready = ($urandom_range(0, 2) != 0);
   end

   // Monitor: collects handshaken results and checks stall/done behaviour.
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", int'(out_data), prev_data);
         end
         if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
         if (out_valid && out_ready) got_q.push_back(int'(out_data));
         if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
         if (done) begin
            done_cnt++;
            check("busy_at_done", busy, 0);
            check("busy_before_done", prev_busy, 1);
         end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = int'(out_data);
      prev_busy  = busy;
   end

   // ------------------------------------------------------- reference model
   function automatic int narrow(input int v);
      int lo, hi, m;
      hi = (1 << (OUT_W - 1)) - 1;
      lo = -(1 << (OUT_W - 1));
`ifdef CONV_SATURATE_EN
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
`else
      m = v & ((1 << OUT_W) - 1);
      if (m > hi) m -= (1 << OUT_W);
      return m;
`endif
   endfunction

   task automatic build_expected(input int w, input int h);
      int acc;
      exp_q.delete();
      for (int r = K - 1; r < h; r++)
         for (int c = K - 1; c < w; c++) begin
            acc = 0;
            for (int i = 0; i < K; i++)
               for (int j = 0; j < K; j++)
                  acc += coef[i*K+j] * pix[r-K+1+i][c-K+1+j];
            exp_q.push_back(narrow((acc + ((1 << SHIFT) >> 1)) >>> SHIFT));
         end
   endtask

   // ----------------------------------------------------------- stimulus
   task automatic set_identity(input int v);
      for (int i = 0; i < NTAP; i++) coef[i] = 0;
      coef[CENTER] = v;
   endtask

   // mode 0: raster index, 1: small random, 2: full-range random, 3: constant
   task automatic fill_pix(input int w, input int h, input int mode, input int val);
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++)
            case (mode)
               0:       pix[r][c] = r * w + c;
               1:       pix[r][c] = int'($urandom_range(0, 100)) - 50;
               2:       pix[r][c] = int'($urandom_range(0, 4095)) - 2048;
               default: pix[r][c] = val;
            endcase
   endtask

   task automatic load_coeffs();
      for (int i = 0; i < NTAP; i++) begin
         @(posedge clk); #1;
         coeff_we   = 1'b1;
         coeff_addr = AW'(i);
         coeff_data = COEFF_W'(coef[i]);
      end
      @(posedge clk); #1;
      coeff_we = 1'b0;
   endtask

   task automatic pulse_start(input int w, input int h);
      @(posedge clk); #1;
      start      = 1'b1;
      cfg_width  = WD_W'(w);
      cfg_height = 16'(h);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Feeds up to 'limit' pixels; 'guard' injects a coefficient write and a
   // second start while the frame is in progress.
   task automatic feed_pixels(input int w, input int limit, input bit bubbles, input bit guard);
      int idx = 0;
      for (int budget = 0; budget < 5000 && idx < limit; budget++) begin
         @(posedge clk); #1;
         start    = 1'b0;
         coeff_we = 1'b0;
         in_valid = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_data  = DATA_W'(pix[idx / w][idx % w]);
         if (guard && idx == 10) begin
            coeff_we   = 1'b1;
            coeff_addr = AW'(CENTER);
            coeff_data = COEFF_W'(coef[CENTER] + 5);
         end
         if (guard && idx == 15) begin
            start      = 1'b1;
            cfg_width  = WD_W'(6);
            cfg_height = 16'd5;
         end
         @(negedge clk);
         if (in_valid && in_ready) begin
            if (idx == (K - 1) * w + K - 1) acc_cyc = cyc;
            idx++;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      start    = 1'b0;
      coeff_we = 1'b0;
      if (idx < limit) check("feed_timeout", idx, limit);
   endtask

   task automatic run_frame(input int w, input int h, input bit bubbles, input bit bp, input bit guard);
      bit seen = 1'b0;
      int n;
      build_expected(w, h);
      got_q.delete();
      done_cnt      = 0;
      first_out_cyc = -1;
      acc_cyc       = -1;
      first_seen    = 1'b0;
      hold          = 0;
      bp_mode       = bp;
      pulse_start(w, h);
      @(negedge clk);
      check("busy_after_start", busy, 1);
      feed_pixels(w, w * h, bubbles, guard);
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      check("done_seen", seen, 1);
      repeat (3) @(posedge clk);
      #1;
      bp_mode = 1'b0;
      @(negedge clk);
      check("n_out", got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check("out", got_q[i], exp_q[i]);
      check("done_cnt", done_cnt, 1);
      check("latency", first_out_cyc - acc_cyc, 3);
      check("busy_idle", busy, 0);
   endtask

   task automatic bad_start(input int w, input int h);
      pulse_start(w, h);
      @(negedge clk);
      check("bad_start_busy", busy, 0);
      check("bad_start_ready", in_ready, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Rejected frame configurations
      bad_start(4, 6);
      bad_start(IMG_W + 1, 6);
      bad_start(8, 4);

      // Identity kernel (unity gain after the shift), clean and stalled
      set_identity(1 << SHIFT);
      load_coeffs();
      fill_pix(8, 6, 0, 0);
      run_frame(8, 6, 1'b0, 1'b0, 1'b0);
      run_frame(8, 6, 1'b1, 1'b1, 1'b0);

      // Rounding, including exact half ties on both signs
      set_identity(3);
      load_coeffs();
      fill_pix(5, 5, 3, 10);
      run_frame(5, 5, 1'b0, 1'b0, 1'b0);
      fill_pix(5, 5, 3, -10);
      run_frame(5, 5, 1'b0, 1'b0, 1'b0);
      set_identity(1);
      load_coeffs();
      fill_pix(5, 5, 3, 8);
      run_frame(5, 5, 1'b0, 1'b0, 1'b0);
      fill_pix(5, 5, 3, -8);
      run_frame(5, 5, 1'b0, 1'b0, 1'b0);

      // Narrowing beyond the output range
      for (int i = 0; i < NTAP; i++) coef[i] = 1;
      load_coeffs();
      fill_pix(5, 5, 3, 100);
      run_frame(5, 5, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < NTAP; i++) coef[i] = 127;
      load_coeffs();
      fill_pix(5, 5, 3, 2047);
      run_frame(5, 5, 1'b0, 1'b0, 1'b0);
      fill_pix(6, 5, 3, -2048);
      run_frame(6, 5, 1'b0, 1'b0, 1'b0);

      // Coefficient write and restart attempts while busy are ignored
      set_identity(1 << SHIFT);
      load_coeffs();
      fill_pix(8, 6, 1, 0);
      run_frame(8, 6, 1'b0, 1'b0, 1'b1);

      // Randomised frames
      for (int t = 0; t < 6; t++) begin
         int w, h;
         bit big;
         w   = $urandom_range(5, 12);
         h   = $urandom_range(5, 8);
         big = $urandom_range(0, 1);
         for (int i = 0; i < NTAP; i++)
            coef[i] = big ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 16)) - 8;
         load_coeffs();
         fill_pix(w, h, big ? 2 : 1, 0);
         run_frame(w, h, $urandom_range(0, 1), $urandom_range(0, 1), 1'b0);
      end

      // Reset in the middle of a frame
      set_identity(1 << SHIFT);
      load_coeffs();
      fill_pix(8, 6, 0, 0);
      done_cnt = 0;
      pulse_start(8, 6);
      feed_pixels(8, 20, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_data", int'(out_data), 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("mid_rst_no_done", done_cnt, 0);

      // Coefficients were cleared: a frame now filters to all zeros
      for (int i = 0; i < NTAP; i++) coef[i] = 0;
      fill_pix(8, 6, 1, 0);
      run_frame(8, 6, 1'b0, 1'b0, 1'b0);

      // Reload and run a fresh frame
      set_identity(1 << SHIFT);
      load_coeffs();
      fill_pix(8, 6, 0, 0);
      run_frame(8, 6, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
